ps2_key_sequencer: RTL and testbench

- Sits between the PS/2 byte receiver and the game's scan-code-to-ASCII conversion/board logic.
- Parses the raw scan-code byte stream: make codes, F0 break prefix, E0 extended prefix, Shift and Caps Lock tracking.
- Produces clean key-press events, each carrying {letter_case, scan_code}, and queues them in a small FIFO with a valid/ready handshake to the consumer.

---
 rtl/ps2_key_sequencer_pkg.sv | 25 ++
 rtl/ps2_key_sequencer_sync_fifo.sv | 60 ++++++
 rtl/ps2_key_sequencer.sv | 154 +++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_sequencer_pkg.sv
// Shared constants, parser state encoding and key-event record for the PS/2 key sequencer.
// Used by ps2_key_sequencer and its sync_fifo event queue.
package ps2_pkg;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] SC_LSHIFT    = 8'h12;
   localparam logic [7:0] SC_RSHIFT    = 8'h59;
   localparam logic [7:0] SC_CAPS      = 8'h58;

   typedef enum logic [1:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK
   } parse_state_t;

   typedef struct packed {
      logic       letter_case;
      logic [7:0] scan_code;
   } key_event_t;

   localparam int EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/ps2_key_sequencer_sync_fifo.sv
// Small synchronous FIFO holding queued key events; head is read straight from storage.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
   import ps2_pkg::*;
#(
   parameter int WIDTH = EVENT_W,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             push_ok,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign push_ok = ~full | do_pop;
   assign do_push = push & push_ok;
   assign dout    = mem[rd_ptr];

   // When full with a simultaneous pop, the write lands in the slot the head is leaving.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code parser producing {letter_case, scan_code} key events into a small FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the most recently pressed key.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_scan_code,
   output logic       out_letter_case,
   output logic       overflow
);

   parse_state_t state;
   parse_state_t state_next;
   logic         shift_l;
   logic         shift_l_next;
   logic         shift_r;
   logic         shift_r_next;
   logic         caps;
   logic         caps_next;
   logic         push;
   logic         push_ok;
   logic         fifo_full;
   logic         fifo_empty;
   key_event_t   new_event;
   key_event_t   head_event;
   logic [EVENT_W-1:0] fifo_dout;

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [7:0] held_code;
   logic [7:0] held_code_next;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shift_l  <= 1'b0;
         shift_r  <= 1'b0;
         caps     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state   <= state_next;
         shift_l <= shift_l_next;
         shift_r <= shift_r_next;
         caps    <= caps_next;
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         held_code <= 8'h00;
      end else begin
         held_code <= held_code_next;
      end
   end
`endif

   // Case is taken from the modifier state before the current byte is applied.
   always_comb begin
      state_next            = state;
      shift_l_next          = shift_l;
      shift_r_next          = shift_r;
      caps_next             = caps;
      push                  = 1'b0;
      new_event.letter_case = (shift_l | shift_r) ^ caps;
      new_event.scan_code   = rx_data;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_code_next        = held_code;
`endif
      if (rx_done_tick) begin
         case (state)
            IDLE: begin
               if (rx_data == BREAK_PREFIX) begin
                  state_next = BRK;
               end else if (rx_data == EXT_PREFIX) begin
                  state_next = EXT;
               end else if (rx_data == SC_LSHIFT) begin
                  shift_l_next = 1'b1;
               end else if (rx_data == SC_RSHIFT) begin
                  shift_r_next = 1'b1;
               end else if (rx_data == SC_CAPS) begin
                  caps_next = ~caps;
               end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                  if (rx_data != held_code) begin
                     push           = 1'b1;
                     held_code_next = rx_data;
                  end
`else
                  push = 1'b1;
`endif
               end
            end
            BRK: begin
               state_next = IDLE;
               if (rx_data == SC_LSHIFT) begin
                  shift_l_next = 1'b0;
               end
               if (rx_data == SC_RSHIFT) begin
                  shift_r_next = 1'b0;
               end
`ifdef PS2_TYPEMATIC_FILTER_EN
               if (rx_data == held_code) begin
                  held_code_next = 8'h00;
               end
`endif
            end
            // Extended keys, including the E0 12 fake shift, are dropped entirely.
            EXT: begin
               state_next = (rx_data == BREAK_PREFIX) ? EXT_BRK : IDLE;
            end
            EXT_BRK: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (EVENT_W),
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W)
   ) u_event_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (out_ready),
      .din     (new_event),
      .dout    (fifo_dout),
      .push_ok (push_ok),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head_event      = fifo_dout;
   assign out_valid       = ~fifo_empty;
   assign out_scan_code   = head_event.scan_code;
   assign out_letter_case = head_event.letter_case;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer with hand-computed expected events.
// Expected typematic behaviour follows PS2_TYPEMATIC_FILTER_EN when it is defined for the build.
module tb_ps2_key_sequencer;

   logic       clk;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_scan_code;
   logic       out_letter_case;
   logic       overflow;

   int vectors;
   int miscompares;
   int valid_cycles;
   logic [8:0] cap_q [$];
   logic [8:0] exp_q [$];

   ps2_key_sequencer #(
      .FIFO_DEPTH (4),
      .PTR_W      (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rx_done_tick    (rx_done_tick),
      .rx_data         (rx_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_scan_code   (out_scan_code),
      .out_letter_case (out_letter_case),
      .overflow        (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every event the consumer accepts; a pop happens on the next rising edge.
   always @(negedge clk) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) cap_q.push_back({out_letter_case, out_scan_code});
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic clearCapture();
      cap_q.delete();
      exp_q.delete();
      valid_cycles = 0;
   endtask

   task automatic checkEvents(input string tag);
      checkOutput({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < cap_q.size())
            checkOutput($sformatf("%s_ev%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      valid_cycles = 0;
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      out_ready    = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(1);

      $display("[TB] reset state");
      checkOutput("rst_valid", 32'(out_valid), 'h0);
      checkOutput("rst_overflow", 32'(overflow), 'h0);
      checkOutput("rst_code", 32'(out_scan_code), 'h00);
      checkOutput("rst_case", 32'(out_letter_case), 'h0);

      $display("[TB] make/break of a single key");
      out_ready = 1'b1;
      clearCapture();
      applyStimulus(8'h16);
      @(negedge clk);
      checkOutput("t1_valid_next", 32'(out_valid), 'h1);
      checkOutput("t1_head_code", 32'(out_scan_code), 'h16);
      applyStimulus(8'hF0);
      applyStimulus(8'h16);
      idle(3);
      checkOutput("t1_valid_cycles", 32'(valid_cycles), 'h1);
      exp_q.push_back({1'b0, 8'h16});
      checkEvents("t1");

      $display("[TB] left shift press and release");
      pulseReset();
      clearCapture();
      applyStimulus(8'h12);
      applyStimulus(8'h22);
      applyStimulus(8'hF0);
      applyStimulus(8'h22);
      applyStimulus(8'hF0);
      applyStimulus(8'h12);
      applyStimulus(8'h22);
      idle(3);
      exp_q.push_back({1'b1, 8'h22});
      exp_q.push_back({1'b0, 8'h22});
      checkEvents("t2");

      $display("[TB] caps lock xor shift");
      pulseReset();
      clearCapture();
      applyStimulus(8'h58);
      applyStimulus(8'h44);
      applyStimulus(8'hF0);
      applyStimulus(8'h44);
      applyStimulus(8'h12);
      applyStimulus(8'h44);
      idle(3);
      exp_q.push_back({1'b1, 8'h44});
      exp_q.push_back({1'b0, 8'h44});
      checkEvents("t3");

      $display("[TB] stalled consumer and overflow");
      pulseReset();
      out_ready = 1'b0;
      clearCapture();
      applyStimulus(8'h16);
      applyStimulus(8'h1E);
      applyStimulus(8'h26);
      applyStimulus(8'h25);
      checkOutput("t4_full_valid", 32'(out_valid), 'h1);
      checkOutput("t4_full_head", 32'(out_scan_code), 'h16);
      checkOutput("t4_no_ovf_yet", 32'(overflow), 'h0);
      applyStimulus(8'h2E);
      checkOutput("t4_ovf_fifth", 32'(overflow), 'h1);
      applyStimulus(8'h36);
      checkOutput("t4_head_held", 32'(out_scan_code), 'h16);
      out_ready = 1'b1;
      idle(6);
      out_ready = 1'b0;
      checkOutput("t4_drained", 32'(out_valid), 'h0);
      checkOutput("t4_ovf_sticky", 32'(overflow), 'h1);
      exp_q.push_back({1'b0, 8'h16});
      exp_q.push_back({1'b0, 8'h1E});
      exp_q.push_back({1'b0, 8'h26});
      exp_q.push_back({1'b0, 8'h25});
      checkEvents("t4");

      $display("[TB] push into full queue with simultaneous pop");
      pulseReset();
      clearCapture();
      applyStimulus(8'h15);
      applyStimulus(8'h1D);
      applyStimulus(8'h24);
      applyStimulus(8'h2D);
      @(posedge clk);
      #1;
      rx_data      = 8'h2C;
      rx_done_tick = 1'b1;
      out_ready    = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
      out_ready    = 1'b0;
      checkOutput("t5_no_ovf", 32'(overflow), 'h0);
      checkOutput("t5_head", 32'(out_scan_code), 'h1D);
      out_ready = 1'b1;
      idle(6);
      exp_q.push_back({1'b0, 8'h15});
      exp_q.push_back({1'b0, 8'h1D});
      exp_q.push_back({1'b0, 8'h24});
      exp_q.push_back({1'b0, 8'h2D});
      exp_q.push_back({1'b0, 8'h2C});
      checkEvents("t5");

      $display("[TB] extended codes discarded");
      pulseReset();
      clearCapture();
      applyStimulus(8'hE0);
      applyStimulus(8'h12);
      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);
      applyStimulus(8'h46);
      applyStimulus(8'h1C);
      idle(3);
      exp_q.push_back({1'b0, 8'h46});
      exp_q.push_back({1'b0, 8'h1C});
      checkEvents("t6");

      $display("[TB] reset mid-sequence");
      out_ready = 1'b0;
      clearCapture();
      applyStimulus(8'h16);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      @(posedge clk);
      #1;
      reset        = 1'b1;
      rx_data      = 8'h55;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      rx_done_tick = 1'b0;
      checkOutput("t7_flushed", 32'(out_valid), 'h0);
      applyStimulus(8'h3D);
      checkOutput("t7_valid", 32'(out_valid), 'h1);
      checkOutput("t7_code", 32'(out_scan_code), 'h3D);
      checkOutput("t7_case", 32'(out_letter_case), 'h0);
      out_ready = 1'b1;
      idle(3);
      exp_q.push_back({1'b0, 8'h3D});
      checkEvents("t7");

      $display("[TB] typematic repeat");
      pulseReset();
      clearCapture();
      applyStimulus(8'h3E);
      applyStimulus(8'h3E);
      applyStimulus(8'h3E);
      applyStimulus(8'hF0);
      applyStimulus(8'h3E);
      applyStimulus(8'h3E);
      idle(3);
      exp_q.push_back({1'b0, 8'h3E});
      exp_q.push_back({1'b0, 8'h3E});
`ifndef PS2_TYPEMATIC_FILTER_EN
      exp_q.push_back({1'b0, 8'h3E});
      exp_q.push_back({1'b0, 8'h3E});
`endif
      checkEvents("t8");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
